// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package arb_pkg;

  localparam int unsigned N     = 4;
  localparam int unsigned REQ_W = 1 << N;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [N-1:0] onehot_idx(input logic [REQ_W-1:0] oh);
    logic [N-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < REQ_W; i++) begin
      if (oh[i]) idx = idx | N'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, circularly.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [(2**N)-1:0] req,
  input  logic [N-1:0]      ptr,
  output logic [(2**N)-1:0] winner
);

  localparam int unsigned REQ_W = 2**N;

  logic [REQ_W-1:0] rot;
  logic [REQ_W-1:0] lsb;

  // Rotate right by ptr so ptr lands at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    rot    = '0;
    winner = '0;
    for (int unsigned j = 0; j < REQ_W; j++) begin
      rot[j] = req[N'(j + ptr)];
    end
    lsb = rot & (~rot + 1'b1);
    for (int unsigned j = 0; j < REQ_W; j++) begin
      winner[j] = lsb[N'(j - ptr)];
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready handshake.
module rr_onehot_arbiter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req,
  output logic             gnt_valid,
  output logic [REQ_W-1:0] gnt_onehot,
  input  logic             gnt_ready
);

  arb_state_t       state, state_d;
  logic [N-1:0]     ptr, ptr_d, pick_ptr;
  logic [REQ_W-1:0] winner, gnt_d;
  logic             hs;

  assign hs        = (state == GRANT) && gnt_ready;
  assign gnt_valid = (state == GRANT);

  // A back-to-back pick must already see the pointer advanced past the grant being accepted.
  always_comb begin
    pick_ptr = ptr;
    if (hs) pick_ptr = onehot_idx(gnt_onehot) + 1'b1;
  end

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner)
  );

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gnt_d   = gnt_onehot;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_d   = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          ptr_d = pick_ptr;
          if (|req) begin
            gnt_d = winner;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_onehot <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      gnt_onehot <= gnt_d;
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed and sticky-random checks for rr_onehot_arbiter.
module tb_rr_onehot_arbiter;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] req;
  logic         gnt_valid;
  logic [W-1:0] gnt_onehot;
  logic         gnt_ready;

  int total;
  int bad;

  rr_onehot_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_ready  (gnt_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req       = '0;
    gnt_ready = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = '0;
    gnt_ready = 1'b0;
    #3;
    total++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state: valid=%b gnt=%h required valid=0 gnt=0000", gnt_valid, gnt_onehot);
    end
    rst_n = 1'b1;
    req = 16'h0008;
    tick();
    total++;
    if (gnt_valid !== 1'b1 || gnt_onehot !== 16'h0008) begin
      bad++;
      $display("FAIL reset_setup: valid=%b gnt=%h required valid=1 gnt=0008", gnt_valid, gnt_onehot);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 16'h0000) begin
      bad++;
      $display("FAIL reset_async: valid=%b gnt=%h required valid=0 gnt=0000", gnt_valid, gnt_onehot);
    end
    req = 16'hFFFF;
    tick();
    total++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 16'h0000) begin
      bad++;
      $display("FAIL reset_held: valid=%b gnt=%h required valid=0 gnt=0000", gnt_valid, gnt_onehot);
    end
    rst_n = 1'b1;
    req = '0;
    tick();
    total++;
    if (gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_req: valid=%b required 0", gnt_valid);
    end
    req = 16'hFFFF;
    tick();
    total++;
    if (gnt_valid !== 1'b1 || gnt_onehot !== 16'h0001) begin
      bad++;
      $display("FAIL reset_first_grant: valid=%b gnt=%h required valid=1 gnt=0001", gnt_valid, gnt_onehot);
    end
  endtask

  task automatic test_single;
    do_reset();
    req = 16'h0010;
    gnt_ready = 1'b1;
    total++;
    if (gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pre: valid=%b required 0", gnt_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (gnt_valid !== 1'b1 || gnt_onehot !== 16'h0010) begin
        bad++;
        $display("FAIL single_grant[%0d]: valid=%b gnt=%h required valid=1 gnt=0010", i, gnt_valid, gnt_onehot);
      end
    end
    req = '0;
    tick();
    total++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 16'h0000) begin
      bad++;
      $display("FAIL single_idle: valid=%b gnt=%h required valid=0 gnt=0000", gnt_valid, gnt_onehot);
    end
  endtask

  task automatic test_rotation;
    logic [W-1:0] exp;
    do_reset();
    req = 16'hFFFF;
    gnt_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      exp = 16'h0001 << (i % 16);
      total++;
      if (gnt_valid !== 1'b1 || gnt_onehot !== exp) begin
        bad++;
        $display("FAIL rotation[%0d]: valid=%b gnt=%h required valid=1 gnt=%h", i, gnt_valid, gnt_onehot, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    req = 16'h0005;
    gnt_ready = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) req = 16'h0004;
      total++;
      if (gnt_valid !== 1'b1 || gnt_onehot !== 16'h0001) begin
        bad++;
        $display("FAIL backpressure_hold[%0d]: valid=%b gnt=%h required valid=1 gnt=0001", i, gnt_valid, gnt_onehot);
      end
      tick();
    end
    gnt_ready = 1'b1;
    tick();
    total++;
    if (gnt_valid !== 1'b1 || gnt_onehot !== 16'h0004) begin
      bad++;
      $display("FAIL backpressure_next: valid=%b gnt=%h required valid=1 gnt=0004", gnt_valid, gnt_onehot);
    end
  endtask

  task automatic test_wrap;
    logic [W-1:0] exp [3];
    exp[0] = 16'h0001;
    exp[1] = 16'h0008;
    exp[2] = 16'h0001;
    do_reset();
    req = 16'h4000;
    tick();
    total++;
    if (gnt_onehot !== 16'h4000) begin
      bad++;
      $display("FAIL wrap_setup: gnt=%h required 4000", gnt_onehot);
    end
    req = 16'h0009;
    gnt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (gnt_valid !== 1'b1 || gnt_onehot !== exp[i]) begin
        bad++;
        $display("FAIL wrap[%0d]: valid=%b gnt=%h required valid=1 gnt=%h", i, gnt_valid, gnt_onehot, exp[i]);
      end
    end
  endtask

  // Requests are sticky until served, so starvation is measured on continuously held requests.
  task automatic test_random;
    logic         mvalid, hs;
    logic [W-1:0] mgnt, old_gnt, old_req, dut_prev;
    logic [3:0]   mptr, sidx;
    int           wait_cnt [W];
    do_reset();
    mvalid = 1'b0;
    mgnt = '0;
    mptr = '0;
    for (int i = 0; i < W; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req = req | W'($urandom & $urandom & $urandom);
      gnt_ready = ($urandom_range(0, 9) < 7);
      old_gnt = mgnt;
      old_req = req;
      dut_prev = gnt_onehot;
      hs = mvalid && gnt_ready;
      if (!mvalid || gnt_ready) begin
        if (hs) begin
          for (int k = 0; k < W; k++) if (mgnt[k]) mptr = 4'(k + 1);
        end
        if (|req) begin
          mgnt = '0;
          for (int k = W - 1; k >= 0; k--) begin
            sidx = 4'(mptr + k);
            if (req[sidx]) mgnt = W'(1) << sidx;
          end
          mvalid = 1'b1;
        end else begin
          mgnt = '0;
          mvalid = 1'b0;
        end
      end
      tick();
      total++;
      if (gnt_valid !== mvalid || gnt_onehot !== mgnt) begin
        bad++;
        $display("FAIL random_model[%0d]: valid=%b gnt=%h required valid=%b gnt=%h", cyc, gnt_valid, gnt_onehot, mvalid, mgnt);
      end
      if (gnt_valid) begin
        total++;
        if ($countones(gnt_onehot) != 1) begin
          bad++;
          $display("FAIL random_onehot[%0d]: gnt=%h required exactly one bit", cyc, gnt_onehot);
        end
        if (old_gnt != '0 && !hs) begin
          total++;
          if (gnt_onehot !== dut_prev) begin
            bad++;
            $display("FAIL random_stall[%0d]: gnt=%h required %h", cyc, gnt_onehot, dut_prev);
          end
        end else begin
          total++;
          if ((gnt_onehot & old_req) == '0) begin
            bad++;
            $display("FAIL random_in_req[%0d]: gnt=%h req=%h required grant within req", cyc, gnt_onehot, old_req);
          end
        end
      end
      if (hs) begin
        for (int k = 0; k < W; k++) begin
          if (old_gnt[k]) begin
            wait_cnt[k] = 0;
          end else if (old_req[k]) begin
            wait_cnt[k]++;
            total++;
            if (wait_cnt[k] > W - 1) begin
              bad++;
              $display("FAIL random_starve[%0d]: requester %0d waited=%0d required <=%0d", cyc, k, wait_cnt[k], W - 1);
            end
          end
        end
        req = req & ~old_gnt;
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    req = '0;
    gnt_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
